uart_byte_display_latch: RTL and testbench
==========================================

// Module: uart_byte_display_latch
// PURPOSE
//   Captures bytes from the UART receiver and splits them into two nibbles for the pair of
//   hex seven-segment decoders on the board. It blanks the display after a configurable
//   idle timeout. It can also show a running count of received bytes instead of the last byte.
//   Sits between the UART RX stage and the two seven-segment decoder instances.
// PARAMETERS
//   TIMEOUT_CLKS  25000000  idle clocks after the last capture before blanking; 0 = never blank
//   CNT_WIDTH     25        width of the idle timer; must hold TIMEOUT_CLKS-1
// PORTS
//   i_Clk           in   1  system clock; all logic on its rising edge
//   i_Reset         in   1  synchronous, active-high reset
//   i_RX_DV         in   1  one-cycle strobe: i_RX_Byte valid this cycle
//   i_RX_Byte       in   8  received byte
//   i_Show_Count    in   1  0 = display last byte, 1 = display received-byte count
//   o_Upper_Nibble  out  4  high nibble to the left decoder (bit 3 = MSB)
//   o_Lower_Nibble  out  4  low nibble to the right decoder (bit 3 = MSB)
//   o_Blank         out  1  1 = top level forces all segments off
//   o_New_Byte      out  1  one-cycle pulse, registered one clock after a capture
// BEHAVIOUR
//   - Reset (dominates every other input, including i_RX_DV in the same cycle):
//     r_Byte=0, r_Count=0, timer=0, state=BLANK, o_Upper/o_Lower=0, o_Blank=1, o_New_Byte=0.
//   - Capture: on an edge with i_RX_DV=1, r_Byte<=i_RX_Byte and r_Count<=r_Count+1.
//     r_Count is 8 bits and wraps 255->0; it counts in both display modes.
//   - Outputs are registered, with latency 1.
//     Displayed value is r_Byte when i_Show_Count=0, else r_Count; the mux select is registered too.
//     o_Upper_Nibble=value[7:4] and o_Lower_Nibble=value[3:0], valid the cycle after capture.
//     A mode change is visible one cycle after i_Show_Count changes.
//   - FSM states: BLANK, SHOW.
//     BLANK: o_Blank=1; on i_RX_DV -> SHOW, timer<=0.
//     SHOW:  o_Blank=0.
//       On i_RX_DV: stay in SHOW, timer<=0.
//       Else if TIMEOUT_CLKS!=0 and timer==TIMEOUT_CLKS-1: -> BLANK, timer<=0.
//       Else: timer<=timer+1 (the timer never wraps).
//     Net effect: o_Blank stays low for exactly TIMEOUT_CLKS cycles after the last capture.
//   - Simultaneous i_RX_DV with timeout expiry: the capture wins; stay in SHOW with the timer cleared.
//   - TIMEOUT_CLKS=0: after the first capture the FSM never leaves SHOW; the timer is held at 0.
//   - Blanking does not clear r_Byte or r_Count; nibbles keep the old value while blanked.
//   - o_New_Byte=1 for exactly one cycle after each capture.
//     Back-to-back strobes give back-to-back pulses.
//   - The count mode does not affect the FSM; o_Blank behaves identically in both modes.
// TESTING (bench uses TIMEOUT_CLKS=8)
//   1. Reset, then idle 20 clks -> nibbles 0/0, o_Blank=1, o_New_Byte=0 throughout.
//   2. DV with byte 0xA7 -> next cycle: Upper=0xA, Lower=0x7, o_Blank=0, o_New_Byte=1 for 1 clk.
//      o_Blank returns to 1 exactly 8 clks after it fell; nibbles still A/7.
//   3. DV 0x3C; 2nd DV 0x5E at the cycle timer==7 -> o_Blank stays 0.
//      Display shows 5/E; blank occurs 8 clks after the second capture.
//   4. 257 DV strobes (bytes arbitrary), then i_Show_Count=1 -> one cycle later nibbles = 0/1.
//      Toggle to 0 -> nibbles show the last byte.
//   5. Assert i_Reset in the same cycle as DV 0xFF while in SHOW -> next cycle nibbles 0/0.
//      Also: o_Blank=1, count=0, no o_New_Byte pulse.
//   6. Rebuild with TIMEOUT_CLKS=0: one DV 0x42, run 1000 clks -> o_Blank stays 0, display 4/2.

Source files
------------

// File: rtl/uart_byte_display_latch.sv
// Latches UART RX bytes (or a running byte count) and splits them into two nibbles
// for the seven-segment decoders. Blanks the display after an idle timeout.
module uart_byte_display_latch #(
  parameter int unsigned TIMEOUT_CLKS = 25000000,
  parameter int unsigned CNT_WIDTH    = 25
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Show_Count,
  output logic [3:0] o_Upper_Nibble,
  output logic [3:0] o_Lower_Nibble,
  output logic       o_Blank,
  output logic       o_New_Byte
);

  typedef enum logic {BLANK, SHOW} state_t;

  localparam bit TIMEOUT_EN = (TIMEOUT_CLKS != 0);
  localparam logic [CNT_WIDTH-1:0] TIMER_LAST =
    CNT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CLKS - 1 : 0);

  state_t               state;
  logic [CNT_WIDTH-1:0] timer;
  logic [7:0]           r_byte;
  logic [7:0]           r_count;
  logic [7:0]           next_byte;
  logic [7:0]           next_count;
  logic [7:0]           disp_value;
  logic                 timeout_hit;

  // The display register loads from the post-capture values so a new byte shows one clock later.
  always_comb begin
    next_byte   = i_RX_DV ? i_RX_Byte : r_byte;
    next_count  = i_RX_DV ? r_count + 8'd1 : r_count;
    disp_value  = i_Show_Count ? next_count : next_byte;
    timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= BLANK;
      timer          <= '0;
      r_byte         <= 8'd0;
      r_count        <= 8'd0;
      o_Upper_Nibble <= 4'd0;
      o_Lower_Nibble <= 4'd0;
      o_Blank        <= 1'b1;
      o_New_Byte     <= 1'b0;
    end else begin
      r_byte         <= next_byte;
      r_count        <= next_count;
      o_Upper_Nibble <= disp_value[7:4];
      o_Lower_Nibble <= disp_value[3:0];
      o_New_Byte     <= i_RX_DV;

      case (state)
        BLANK: begin
          if (i_RX_DV) begin
            state   <= SHOW;
            timer   <= '0;
            o_Blank <= 1'b0;
          end else begin
            o_Blank <= 1'b1;
          end
        end
        SHOW: begin
          // A capture in the expiry cycle wins and restarts the idle window.
          if (i_RX_DV) begin
            timer   <= '0;
            o_Blank <= 1'b0;
          end else if (timeout_hit) begin
            state   <= BLANK;
            timer   <= '0;
            o_Blank <= 1'b1;
          end else begin
            if (TIMEOUT_EN && (timer != '1)) timer <= timer + 1'b1;
            o_Blank <= 1'b0;
          end
        end
        default: begin
          state   <= BLANK;
          timer   <= '0;
          o_Blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_display_latch.sv
// Self-checking bench: table-driven vectors feed a scoreboard queue that is popped
// and compared one clock later, on the falling edge.
module tb_uart_byte_display_latch;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] data;
    logic       show;
    logic [3:0] up;
    logic [3:0] lo;
    logic       blank;
    logic       nb;
    int         reps;
  } vec_t;

  typedef struct {
    logic [3:0] up;
    logic [3:0] lo;
    logic       blank;
    logic       nb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic       show;
  logic [7:0] data;
  logic [3:0] up8, lo8, up0, lo0;
  logic       blank8, nb8, blank0, nb0;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  exp_t sb[$];
  exp_t sb0[$];
  vec_t vecs[12];
  exp_t none;

  uart_byte_display_latch #(.TIMEOUT_CLKS(8), .CNT_WIDTH(4)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_RX_DV(dv), .i_RX_Byte(data), .i_Show_Count(show),
    .o_Upper_Nibble(up8), .o_Lower_Nibble(lo8), .o_Blank(blank8), .o_New_Byte(nb8)
  );

  uart_byte_display_latch #(.TIMEOUT_CLKS(0), .CNT_WIDTH(4)) dut_zero (
    .i_Clk(clk), .i_Reset(rst), .i_RX_DV(dv), .i_RX_Byte(data), .i_Show_Count(show),
    .o_Upper_Nibble(up0), .o_Lower_Nibble(lo0), .o_Blank(blank0), .o_New_Byte(nb0)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(bit r, bit d, logic [7:0] b, bit s,
                              logic [3:0] u, logic [3:0] l, bit bl, bit n, int k);
    vec_t v;
    v.rst = r; v.dv = d; v.data = b; v.show = s;
    v.up = u; v.lo = l; v.blank = bl; v.nb = n; v.reps = k;
    return v;
  endfunction

  task automatic compare(input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d: got %h, required %h", nm, cycle, got, want);
    end
  endtask

  task automatic checkOutput(input string nm, input bit zc);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL %s: got empty scoreboard, required entry", nm);
    end else begin
      e = sb.pop_front();
      compare({nm, " upper"}, {4'd0, up8}, {4'd0, e.up});
      compare({nm, " lower"}, {4'd0, lo8}, {4'd0, e.lo});
      compare({nm, " blank"}, {7'd0, blank8}, {7'd0, e.blank});
      compare({nm, " new_byte"}, {7'd0, nb8}, {7'd0, e.nb});
    end
    if (zc) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL %s t0: got empty scoreboard, required entry", nm);
      end else begin
        e = sb0.pop_front();
        compare({nm, " t0 upper"}, {4'd0, up0}, {4'd0, e.up});
        compare({nm, " t0 lower"}, {4'd0, lo0}, {4'd0, e.lo});
        compare({nm, " t0 blank"}, {7'd0, blank0}, {7'd0, e.blank});
        compare({nm, " t0 new_byte"}, {7'd0, nb0}, {7'd0, e.nb});
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string nm, input bit zc, input exp_t e0);
    exp_t e;
    for (int k = 0; k < v.reps; k++) begin
      rst = v.rst; dv = v.dv; data = v.data; show = v.show;
      e.up = v.up; e.lo = v.lo; e.blank = v.blank; e.nb = v.nb;
      sb.push_back(e);
      if (zc) sb0.push_back(e0);
      @(posedge clk);
      @(negedge clk);
      cycle++;
      checkOutput(nm, zc);
    end
  endtask

  initial begin
    exp_t e0;
    logic [7:0] b;
    none = '{up: 4'h0, lo: 4'h0, blank: 1'b0, nb: 1'b0};
    rst = 1'b1; dv = 1'b0; data = 8'h00; show = 1'b0;

    // Reset/idle, single capture with timeout, re-capture at the expiry cycle.
    vecs[0]  = mk(1, 0, 8'h00, 0, 4'h0, 4'h0, 1, 0, 2);
    vecs[1]  = mk(0, 0, 8'h00, 0, 4'h0, 4'h0, 1, 0, 20);
    vecs[2]  = mk(0, 1, 8'hA7, 0, 4'hA, 4'h7, 0, 1, 1);
    vecs[3]  = mk(0, 0, 8'h00, 0, 4'hA, 4'h7, 0, 0, 7);
    vecs[4]  = mk(0, 0, 8'h00, 0, 4'hA, 4'h7, 1, 0, 3);
    vecs[5]  = mk(0, 1, 8'h3C, 0, 4'h3, 4'hC, 0, 1, 1);
    vecs[6]  = mk(0, 0, 8'h00, 0, 4'h3, 4'hC, 0, 0, 7);
    vecs[7]  = mk(0, 1, 8'h5E, 0, 4'h5, 4'hE, 0, 1, 1);
    vecs[8]  = mk(0, 0, 8'h00, 0, 4'h5, 4'hE, 0, 0, 7);
    vecs[9]  = mk(0, 0, 8'h00, 0, 4'h5, 4'hE, 1, 0, 2);
    vecs[10] = mk(0, 0, 8'h00, 1, 4'h0, 4'h3, 1, 0, 1);
    vecs[11] = mk(0, 0, 8'h00, 0, 4'h5, 4'hE, 1, 0, 1);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i), 1'b0, none);

    // Counter wrap: 257 captures leave the count at 1.
    applyStimulus(mk(1, 0, 8'h00, 0, 4'h0, 4'h0, 1, 0, 1), "t4 reset", 1'b0, none);
    for (int i = 0; i < 257; i++) begin
      b = 8'(i * 37 + 5);
      applyStimulus(mk(0, 1, b, 0, b[7:4], b[3:0], 0, 1, 1), "t4 strobe", 1'b0, none);
    end
    applyStimulus(mk(0, 0, 8'h00, 1, 4'h0, 4'h1, 0, 0, 1), "t4 count", 1'b0, none);
    applyStimulus(mk(0, 0, 8'h00, 0, 4'h0, 4'h5, 0, 0, 1), "t4 byte", 1'b0, none);
    applyStimulus(mk(0, 1, 8'h99, 1, 4'h0, 4'h2, 0, 1, 1), "t4 count dv", 1'b0, none);
    applyStimulus(mk(0, 0, 8'h00, 0, 4'h9, 4'h9, 0, 0, 1), "t4 byte after", 1'b0, none);

    // Reset beats a simultaneous strobe.
    applyStimulus(mk(1, 1, 8'hFF, 0, 4'h0, 4'h0, 1, 0, 1), "t5 reset+dv", 1'b0, none);
    applyStimulus(mk(0, 0, 8'h00, 1, 4'h0, 4'h0, 1, 0, 1), "t5 count", 1'b0, none);
    applyStimulus(mk(0, 0, 8'h00, 0, 4'h0, 4'h0, 1, 0, 1), "t5 byte", 1'b0, none);

    // TIMEOUT_CLKS=0 instance never blanks after its first capture.
    e0 = '{up: 4'h0, lo: 4'h0, blank: 1'b1, nb: 1'b0};
    applyStimulus(mk(1, 0, 8'h00, 0, 4'h0, 4'h0, 1, 0, 1), "t6 reset", 1'b1, e0);
    e0 = '{up: 4'h4, lo: 4'h2, blank: 1'b0, nb: 1'b1};
    applyStimulus(mk(0, 1, 8'h42, 0, 4'h4, 4'h2, 0, 1, 1), "t6 dv", 1'b1, e0);
    e0 = '{up: 4'h4, lo: 4'h2, blank: 1'b0, nb: 1'b0};
    applyStimulus(mk(0, 0, 8'h00, 0, 4'h4, 4'h2, 0, 0, 7), "t6 idle", 1'b1, e0);
    applyStimulus(mk(0, 0, 8'h00, 0, 4'h4, 4'h2, 1, 0, 993), "t6 long", 1'b1, e0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
